// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks a one-hot column drive, synchronizes the row
// sense lines, debounces one key at a time and reports its code
// ({row_idx, col_idx}) with a one-cycle key_valid pulse.
module keypad_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] IO_P4_ROW,
  output logic [3:0] IO_P4_COL,
  output logic [3:0] number,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CMAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_DONE   = CW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t      state, state_next;
  logic [3:0]  row_meta, srow;
  logic [1:0]  col_idx, col_next;
  logic [CW-1:0] dwell, dwell_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]  row_lat, row_lat_next;
  logic [3:0]  number_next;
  logic        valid_next;
  logic        one_hot;

  function automatic logic [1:0] bit_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  assign one_hot = (srow != '0) && ((srow & (srow - 4'd1)) == '0);

  // Two-flop synchronizer for the asynchronous row sense lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= '0;
      srow     <= '0;
    end else begin
      row_meta <= IO_P4_ROW;
      srow     <= row_meta;
    end
  end

  // State register plus the datapath registers that travel with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      col_idx   <= '0;
      dwell     <= '0;
      cnt       <= '0;
      row_lat   <= '0;
      number    <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_next;
      col_idx   <= col_next;
      dwell     <= dwell_next;
      cnt       <= cnt_next;
      row_lat   <= row_lat_next;
      number    <= number_next;
      key_valid <= valid_next;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_next   = state;
    col_next     = col_idx;
    dwell_next   = dwell;
    cnt_next     = cnt;
    row_lat_next = row_lat;
    number_next  = number;
    valid_next   = 1'b0;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_next = '0;
          if (one_hot) begin
            row_lat_next = srow;
            cnt_next     = '0;
            state_next   = DEBOUNCE;
          end else begin
            col_next = col_idx + 2'd1;
          end
        end else begin
          dwell_next = dwell + CW'(1);
        end
      end
      DEBOUNCE: begin
        // Once the count is reached the key is accepted on the next edge
        if (cnt == DEB_DONE) begin
          number_next = {bit_idx(row_lat), col_idx};
          valid_next  = 1'b1;
          state_next  = HELD;
        end else if (srow != row_lat) begin
          dwell_next = '0;
          state_next = SCAN;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      HELD: begin
        if (srow == '0) begin
          cnt_next   = '0;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (cnt == DEB_DONE) begin
          col_next   = '0;
          dwell_next = '0;
          state_next = SCAN;
        end else if (srow != '0) begin
          state_next = HELD;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = SCAN;
    endcase
  end

  // Moore outputs: column drive and held flag follow state directly
  always_comb begin
    IO_P4_COL = 4'b0001 << col_idx;
    key_held  = (state == HELD) || (state == RELEASE);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] IO_P4_ROW;
  logic [3:0] IO_P4_COL;
  logic [3:0] number;
  logic       key_valid;
  logic       key_held;

  int checks   = 0;
  int failures = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .IO_P4_ROW (IO_P4_ROW),
    .IO_P4_COL (IO_P4_COL),
    .number    (number),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) until the scan moves onto the target column; returns at its first cycle.
  task automatic wait_col(input logic [3:0] target, output logic ok);
    int n;
    n = 0;
    while (IO_P4_COL == target && n < 40) begin @(negedge clk); n++; end
    while (IO_P4_COL != target && n < 80) begin @(negedge clk); n++; end
    ok = (IO_P4_COL == target);
  endtask

  // Wait (bounded) for key_valid; idx is the negedge count at which it was seen, -1 if never.
  task automatic wait_pulse(input int budget, output int idx, output logic [3:0] num,
                            output logic [3:0] col, output logic held);
    idx = -1; num = '0; col = '0; held = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (key_valid) begin
        idx = i; num = number; col = IO_P4_COL; held = key_held;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (key_valid) p++;
    end
  endtask

  // Let a pressed key go and confirm the release debounce timing
  task automatic release_key(input string tag);
    IO_P4_ROW = 4'b0000;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 11) check({tag, "_held_before"}, key_held, 1);
      if (i == 12) begin
        check({tag, "_held_after"}, key_held, 0);
        check({tag, "_col_restart"}, IO_P4_COL, 4'b0001);
      end
    end
  endtask

  initial begin
    logic ok;
    int idx, p, bad;
    logic [3:0] num, col, exp_col;
    logic held;

    reset = 1'b0;
    IO_P4_ROW = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_col", IO_P4_COL, 4'b0001);
    check("rst_number", number, 0);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);

    // Idle scan: four cycles per column, wraps back to column 0
    reset = 1'b1;
    check("scan_k0", IO_P4_COL, 4'b0001);
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      exp_col = 4'b0001 << ((k / 4) % 4);
      check("scan_col", IO_P4_COL, exp_col);
      check("scan_novalid", key_valid, 0);
    end

    // Key row 1 / col 2 -> number 6
    wait_col(4'b0100, ok);
    check("k6_wait_col", ok, 1);
    IO_P4_ROW = 4'b0010;
    wait_pulse(30, idx, num, col, held);
    check("k6_latency", idx, 13);
    check("k6_number", num, 6);
    check("k6_col_frozen", col, 4'b0100);
    check("k6_held", held, 1);
    count_pulses(20, p);
    check("k6_single_pulse", p, 0);
    check("k6_still_frozen", IO_P4_COL, 4'b0100);
    check("k6_number_hold", number, 6);
    release_key("k6");

    // Bouncing row: stable runs of only 3 cycles never qualify
    bad = 0;
    for (int r = 0; r < 10; r++) begin
      IO_P4_ROW = 4'b0001;
      count_pulses(3, p); bad += p;
      IO_P4_ROW = 4'b0000;
      count_pulses(3, p); bad += p;
    end
    check("bounce_no_pulse", bad, 0);
    check("bounce_number_kept", number, 6);
    repeat (8) @(negedge clk);
    wait_col(4'b0001, ok);
    check("k0_wait_col", ok, 1);
    IO_P4_ROW = 4'b0001;
    wait_pulse(30, idx, num, col, held);
    check("k0_latency", idx, 13);
    check("k0_number", num, 0);
    release_key("k0");

    // Two rows at once is not a press
    IO_P4_ROW = 4'b0011;
    count_pulses(40, p);
    check("multi_no_pulse", p, 0);
    check("multi_not_held", key_held, 0);
    IO_P4_ROW = 4'b0000;
    repeat (4) @(negedge clk);
    wait_col(4'b1000, ok);
    check("k15_wait_col", ok, 1);
    IO_P4_ROW = 4'b1000;
    wait_pulse(30, idx, num, col, held);
    check("k15_latency", idx, 13);
    check("k15_number", num, 15);
    release_key("k15");

    // Key 10, then short release glitches while held
    wait_col(4'b0100, ok);
    check("k10_wait_col", ok, 1);
    IO_P4_ROW = 4'b0100;
    wait_pulse(30, idx, num, col, held);
    check("k10_number", num, 10);
    bad = 0; p = 0;
    for (int g = 0; g < 3; g++) begin
      IO_P4_ROW = 4'b0000;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (!key_held) bad++;
        if (key_valid) p++;
      end
      IO_P4_ROW = 4'b0100;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (!key_held) bad++;
        if (key_valid) p++;
      end
    end
    check("glitch_held_drops", bad, 0);
    check("glitch_pulses", p, 0);

    // Asynchronous reset while held
    #1 reset = 1'b0;
    #1;
    check("arst_col", IO_P4_COL, 4'b0001);
    check("arst_number", number, 0);
    check("arst_valid", key_valid, 0);
    check("arst_held", key_held, 0);
    repeat (2) @(negedge clk);
    IO_P4_ROW = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    p = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (key_valid) p++;
      if (k == 3) check("resume_k3", IO_P4_COL, 4'b0001);
      if (k == 4) check("resume_k4", IO_P4_COL, 4'b0010);
    end
    check("post_hold_reset_pulses", p, 0);

    // Reset in the middle of debounce abandons the key
    wait_col(4'b0010, ok);
    check("mid_wait_col", ok, 1);
    IO_P4_ROW = 4'b0001;
    count_pulses(8, p);
    check("mid_no_early_pulse", p, 0);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_col", IO_P4_COL, 4'b0001);
    IO_P4_ROW = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    count_pulses(40, p);
    check("mid_post_pulses", p, 0);
    check("mid_number", number, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
